// File: rtl/icache_controller.sv
// Instruction cache sequencer: lookup, miss refill with replay, whole-cache flush.
// Ports: fetch_* front end, array_* tag/data arrays, mem_* refill; ICACHE_PERF_COUNTERS_EN adds hit/miss counts.
module icache_controller #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          fetch_request_i,
  input  logic [31:0]                   fetch_address_i,
  output logic                          fetch_hit_o,
  output logic                          fetch_stall_o,
  input  logic                          flush_i,
  output logic                          array_lookup_o,
  output logic [31:0]                   array_address_o,
  input  logic                          array_hit_i,
  output logic                          array_write_o,
  output logic [$clog2(LINE_WORDS)-1:0] array_write_offset_o,
  output logic [31:0]                   array_write_data_o,
  output logic                          array_validate_o,
  output logic                          array_invalidate_o,
  output logic [$clog2(SETS)-1:0]       array_set_o,
  output logic                          mem_request_o,
  output logic [31:0]                   mem_address_o,
  input  logic                          mem_grant_i,
  input  logic                          mem_valid_i,
  input  logic [31:0]                   mem_data_i
`ifdef ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]                   hit_count_o,
  output logic [31:0]                   miss_count_o
`endif
);

  localparam int OFFW = $clog2(LINE_WORDS);
  localparam int SETW = $clog2(SETS);
  localparam logic [OFFW-1:0] LAST_W = OFFW'(LINE_WORDS - 1);
  localparam logic [SETW-1:0] LAST_S = SETW'(SETS - 1);

  typedef enum logic [2:0] {
    IDLE, COMPARE, MEM_REQ, REFILL, FLUSH
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [OFFW-1:0] cnt_q, cnt_d;
  logic [SETW-1:0] set_q, set_d;
  logic            pend_q, pend_d;
  logic            replay_q, replay_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      set_q    <= '0;
      pend_q   <= 1'b0;
      replay_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      set_q    <= set_d;
      pend_q   <= pend_d;
      replay_q <= replay_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    addr_d               = addr_q;
    cnt_d                = cnt_q;
    set_d                = set_q;
    pend_d               = pend_q;
    replay_d             = replay_q;
    fetch_hit_o          = 1'b0;
    fetch_stall_o        = 1'b1;
    array_lookup_o       = 1'b0;
    array_address_o      = addr_q;
    array_write_o        = 1'b0;
    array_write_offset_o = '0;
    array_write_data_o   = '0;
    array_validate_o     = 1'b0;
    array_invalidate_o   = 1'b0;
    array_set_o          = '0;
    mem_request_o        = 1'b0;
    mem_address_o        = '0;
    unique case (state_q)
      IDLE: begin
        fetch_stall_o = 1'b0;
        if (flush_i || pend_q) begin
          state_d = FLUSH;
          set_d   = '0;
        end else if (fetch_request_i) begin
          array_lookup_o  = 1'b1;
          array_address_o = fetch_address_i;
          addr_d          = fetch_address_i;
          replay_d        = 1'b0;
          state_d         = COMPARE;
        end
      end
      COMPARE: begin
        if (flush_i) pend_d = 1'b1;
        if (array_hit_i) begin
          fetch_hit_o   = 1'b1;
          fetch_stall_o = 1'b0;
          replay_d      = 1'b0;
          state_d       = IDLE;
        end else begin
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (flush_i) pend_d = 1'b1;
        mem_request_o = 1'b1;
        mem_address_o = {addr_q[31:OFFW+2], {(OFFW+2){1'b0}}};
        if (mem_grant_i) begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (flush_i) pend_d = 1'b1;
        if (mem_valid_i) begin
          array_write_o        = 1'b1;
          array_write_offset_o = cnt_q;
          array_write_data_o   = mem_data_i;
          if (cnt_q == LAST_W) begin
            // Validate with the last word and replay the lookup at once.
            array_validate_o = 1'b1;
            array_lookup_o   = 1'b1;
            cnt_d            = '0;
            replay_d         = 1'b1;
            state_d          = COMPARE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        array_invalidate_o = 1'b1;
        array_set_o        = set_q;
        if (set_q == LAST_S) begin
          set_d   = '0;
          pend_d  = 1'b0;
          state_d = IDLE;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == FLUSH) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == COMPARE) begin
      if (array_hit_i && !replay_q) hit_q <= hit_q + 1'b1;
      if (!array_hit_i)             miss_q <= miss_q + 1'b1;
    end
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller: hit, miss/refill, grant delay,
// flush during refill, flush vs fetch, reset mid-refill.
module tb_icache_controller;

  logic        clk;
  logic        rst_n;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic        fetch_hit;
  logic        fetch_stall;
  logic        flush;
  logic        array_lookup;
  logic [31:0] array_address;
  logic        array_hit;
  logic        array_write;
  logic [1:0]  array_write_offset;
  logic [31:0] array_write_data;
  logic        array_validate;
  logic        array_invalidate;
  logic [5:0]  array_set;
  logic        mem_request;
  logic [31:0] mem_address;
  logic        mem_grant;
  logic        mem_valid;
  logic [31:0] mem_data;

  int checks = 0;
  int errors = 0;

  icache_controller #(.LINE_WORDS(4), .SETS(64)) dut (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .fetch_request_i      (fetch_request),
    .fetch_address_i      (fetch_address),
    .fetch_hit_o          (fetch_hit),
    .fetch_stall_o        (fetch_stall),
    .flush_i              (flush),
    .array_lookup_o       (array_lookup),
    .array_address_o      (array_address),
    .array_hit_i          (array_hit),
    .array_write_o        (array_write),
    .array_write_offset_o (array_write_offset),
    .array_write_data_o   (array_write_data),
    .array_validate_o     (array_validate),
    .array_invalidate_o   (array_invalidate),
    .array_set_o          (array_set),
    .mem_request_o        (mem_request),
    .mem_address_o        (mem_address),
    .mem_grant_i          (mem_grant),
    .mem_valid_i          (mem_valid),
    .mem_data_i           (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a request that misses and get the memory grant; leaves FSM in REFILL.
  task automatic start_miss(input logic [31:0] a);
    fetch_request = 1'b1;
    fetch_address = a;
    tick();
    fetch_request = 1'b0;
    array_hit = 1'b0;
    tick();
    mem_grant = 1'b1;
    tick();
    mem_grant = 1'b0;
  endtask

  task automatic feed_word(input logic [31:0] d);
    mem_valid = 1'b1;
    mem_data  = d;
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    fetch_request = 0; fetch_address = 0; flush = 0; array_hit = 0;
    mem_grant = 0; mem_valid = 1; mem_data = 32'hdead_beef;
    #2;
    checks++;
    if ({fetch_hit, fetch_stall, array_lookup, array_write, array_validate,
         array_invalidate, mem_request} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
        {fetch_hit, fetch_stall, array_lookup, array_write, array_validate,
         array_invalidate, mem_request});
    end
    checks++;
    if ({array_address, mem_address, array_write_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {array_address, mem_address, array_write_data});
    end
    mem_valid = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_hit;
    fetch_request = 1'b1;
    fetch_address = 32'h100;
    #1;
    checks++;
    if (array_lookup !== 1'b1 || array_address !== 32'h100 || fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL hit_lookup: got lk=%b a=%h st=%b want 1 100 0",
        array_lookup, array_address, fetch_stall);
    end
    tick();
    fetch_request = 1'b0;
    array_hit = 1'b1;
    #1;
    checks++;
    if (fetch_hit !== 1'b1 || fetch_stall !== 1'b0 || mem_request !== 1'b0) begin
      errors++;
      $display("FAIL hit_result: got hit=%b st=%b mr=%b want 1 0 0",
        fetch_hit, fetch_stall, mem_request);
    end
    tick();
    array_hit = 1'b0;
  endtask

  task automatic test_back_to_back;
    fetch_request = 1'b1;
    fetch_address = 32'h200;
    #1;
    checks++;
    if (array_lookup !== 1'b1 || array_address !== 32'h200) begin
      errors++;
      $display("FAIL b2b_accept: got lk=%b a=%h want 1 200", array_lookup, array_address);
    end
    tick();
    fetch_request = 1'b0;
    array_hit = 1'b1;
    tick();
    array_hit = 1'b0;
  endtask

  task automatic test_miss;
    fetch_request = 1'b1;
    fetch_address = 32'h104;
    tick();
    fetch_request = 1'b0;
    array_hit = 1'b0;
    #1;
    checks++;
    if (fetch_hit !== 1'b0 || fetch_stall !== 1'b1) begin
      errors++;
      $display("FAIL miss_compare: got hit=%b st=%b want 0 1", fetch_hit, fetch_stall);
    end
    tick();
    checks++;
    if (mem_request !== 1'b1 || mem_address !== 32'h100) begin
      errors++;
      $display("FAIL miss_memreq: got mr=%b ma=%h want 1 100", mem_request, mem_address);
    end
    mem_grant = 1'b1;
    tick();
    mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (array_write !== 1'b0 || fetch_stall !== 1'b1) begin
        errors++;
        $display("FAIL miss_gap%0d: got wr=%b st=%b want 0 1", i, array_write, fetch_stall);
      end
      tick();
      mem_valid = 1'b1;
      mem_data  = 32'ha0 + 32'(i);
      #1;
      checks++;
      if (array_write !== 1'b1 || array_write_offset !== 2'(i) ||
          array_write_data !== 32'ha0 + 32'(i) || array_validate !== (i == 3) ||
          array_lookup !== (i == 3)) begin
        errors++;
        $display("FAIL miss_word%0d: got wr=%b off=%0d d=%h v=%b lk=%b want 1 %0d %h %b %b",
          i, array_write, array_write_offset, array_write_data, array_validate,
          array_lookup, i, 32'ha0 + 32'(i), i == 3, i == 3);
      end
      if (i == 3) begin
        checks++;
        if (array_address !== 32'h104) begin
          errors++;
          $display("FAIL miss_replay_addr: got %h want 104", array_address);
        end
      end
      tick();
      mem_valid = 1'b0;
    end
    array_hit = 1'b1;
    #1;
    checks++;
    if (fetch_hit !== 1'b1 || fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL miss_replay_hit: got hit=%b st=%b want 1 0", fetch_hit, fetch_stall);
    end
    tick();
    array_hit = 1'b0;
  endtask

  task automatic test_grant_delay;
    fetch_request = 1'b1;
    fetch_address = 32'h20c;
    tick();
    fetch_request = 1'b0;
    array_hit = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (mem_request !== 1'b1 || mem_address !== 32'h200) begin
        errors++;
        $display("FAIL grant_wait%0d: got mr=%b ma=%h want 1 200", i, mem_request, mem_address);
      end
      tick();
    end
    mem_grant = 1'b1;
    tick();
    mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) feed_word(32'hb0 + 32'(i));
    array_hit = 1'b1;
    #1;
    checks++;
    if (fetch_hit !== 1'b1) begin
      errors++;
      $display("FAIL grant_replay: got hit=%b want 1", fetch_hit);
    end
    tick();
    array_hit = 1'b0;
  endtask

  task automatic test_flush_refill;
    start_miss(32'h300);
    feed_word(32'hc0);
    flush = 1'b1;
    feed_word(32'hc1);
    flush = 1'b0;
    feed_word(32'hc2);
    feed_word(32'hc3);
    array_hit = 1'b1;
    #1;
    checks++;
    if (fetch_hit !== 1'b1 || array_invalidate !== 1'b0) begin
      errors++;
      $display("FAIL flush_refill_hit: got hit=%b inv=%b want 1 0", fetch_hit, array_invalidate);
    end
    tick();
    array_hit = 1'b0;
    #1;
    checks++;
    if (array_invalidate !== 1'b0 || array_lookup !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got inv=%b lk=%b want 0 0", array_invalidate, array_lookup);
    end
    tick();
    for (int s = 0; s < 64; s++) begin
      checks++;
      if (array_invalidate !== 1'b1 || array_set !== 6'(s) || fetch_stall !== 1'b1) begin
        errors++;
        $display("FAIL flush_set%0d: got inv=%b set=%0d st=%b want 1 %0d 1",
          s, array_invalidate, array_set, fetch_stall, s);
      end
      tick();
    end
    checks++;
    if (array_invalidate !== 1'b0 || fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_done: got inv=%b st=%b want 0 0", array_invalidate, fetch_stall);
    end
  endtask

  task automatic test_flush_vs_fetch;
    flush = 1'b1;
    fetch_request = 1'b1;
    fetch_address = 32'h500;
    #1;
    checks++;
    if (array_lookup !== 1'b0) begin
      errors++;
      $display("FAIL ffetch_prio: got lk=%b want 0", array_lookup);
    end
    tick();
    flush = 1'b0;
    for (int s = 0; s < 64; s++) begin
      checks++;
      if (array_lookup !== 1'b0 || array_invalidate !== 1'b1 || array_set !== 6'(s)) begin
        errors++;
        $display("FAIL ffetch_set%0d: got lk=%b inv=%b set=%0d want 0 1 %0d",
          s, array_lookup, array_invalidate, array_set, s);
      end
      tick();
    end
    checks++;
    if (array_lookup !== 1'b1 || array_address !== 32'h500) begin
      errors++;
      $display("FAIL ffetch_accept: got lk=%b a=%h want 1 500", array_lookup, array_address);
    end
    tick();
    fetch_request = 1'b0;
    array_hit = 1'b1;
    tick();
    array_hit = 1'b0;
  endtask

  task automatic test_reset_mid_refill;
    start_miss(32'h400);
    feed_word(32'hd0);
    feed_word(32'hd1);
    mem_valid = 1'b1;
    mem_data  = 32'hd2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({array_write, array_validate, mem_request, fetch_stall, array_lookup} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid: got %b want 00000",
        {array_write, array_validate, mem_request, fetch_stall, array_lookup});
    end
    tick();
    rst_n = 1'b1;
    mem_data = 32'hd3;
    #1;
    checks++;
    if (array_write !== 1'b0 || array_validate !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_beat: got wr=%b v=%b want 0 0", array_write, array_validate);
    end
    tick();
    mem_valid = 1'b0;
    fetch_request = 1'b1;
    fetch_address = 32'h600;
    #1;
    checks++;
    if (array_lookup !== 1'b1 || array_address !== 32'h600) begin
      errors++;
      $display("FAIL rst_recover: got lk=%b a=%h want 1 600", array_lookup, array_address);
    end
    tick();
    fetch_request = 1'b0;
    array_hit = 1'b1;
    tick();
    array_hit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_back_to_back();
    test_miss();
    test_grant_delay();
    test_flush_refill();
    test_flush_vs_fetch();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
